// File: rtl/cluster_pkg.sv
// cluster_pkg: shared definitions for the cluster_layer slice.
//   state_t  - controller states
//   STATUS_* - codes driven on the status port
//   requant  - shift / optional ReLU / saturate of an accumulator value
package cluster_pkg;

    typedef enum logic [1:0] {
        S_BIAS  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [1:0] STATUS_IDLE    = 2'b00;
    localparam logic [1:0] STATUS_COMPUTE = 2'b01;
    localparam logic [1:0] STATUS_OUTPUT  = 2'b10;

    // Works on a 64-bit sign-extended copy so one function serves every
    // ACC_BITS/OUT_BITS combination; the caller truncates to OUT_BITS.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int                 out_shift,
        input int                 out_bits,
        input logic               relu_en
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc >>> out_shift;
        if (relu_en) begin
            hi = (64'sd1 <<< out_bits) - 64'sd1;
            lo = '0;
        end else begin
            hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (out_bits - 1));
        end
        if (r < lo) begin
            r = lo;
        end else if (r > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/cluster_layer_if.sv
// cluster_layer_if: the four AXI-stream style channels of one layer slice
// plus its status code.
//   x  : input activation stream        (IN_BITS)
//   w  : weight vector stream           (NUM_NEURONS*W_BITS)
//   b  : bias vector stream             (NUM_NEURONS*B_BITS)
//   a  : output activation stream       (OUT_BITS, with a_tlast)
//   status : 00 idle/bias wait, 01 computing, 10 outputting
// Modports: slave = the layer slice, master = the surrounding fabric
// (DMA streams feeding x/w/b and the consumer of a).
interface cluster_layer_if #(
    parameter int IN_BITS     = 4,
    parameter int NUM_NEURONS = 16,
    parameter int W_BITS      = 4,
    parameter int B_BITS      = 4,
    parameter int OUT_BITS    = 4
);
    logic [IN_BITS-1:0]            x_tdata;
    logic                          x_tvalid;
    logic                          x_tready;
    logic [NUM_NEURONS*W_BITS-1:0] w_tdata;
    logic                          w_tvalid;
    logic                          w_tready;
    logic [NUM_NEURONS*B_BITS-1:0] b_tdata;
    logic                          b_tvalid;
    logic                          b_tready;
    logic [OUT_BITS-1:0]           a_tdata;
    logic                          a_tvalid;
    logic                          a_tready;
    logic                          a_tlast;
    logic [1:0]                    status;

    modport slave (
        input  x_tdata, x_tvalid, output x_tready,
        input  w_tdata, w_tvalid, output w_tready,
        input  b_tdata, b_tvalid, output b_tready,
        output a_tdata, a_tvalid, a_tlast, input a_tready,
        output status
    );

    modport master (
        output x_tdata, x_tvalid, input x_tready,
        output w_tdata, w_tvalid, input w_tready,
        output b_tdata, b_tvalid, input b_tready,
        input  a_tdata, a_tvalid, a_tlast, output a_tready,
        input  status
    );
endinterface

// File: rtl/cluster_layer_mac_lane.sv
// mac_lane: one neuron's multiply-accumulate datapath.
//   CLK, RST  : clock, synchronous active-low reset
//   load      : preload acc with load_val (bias)
//   load_val  : preload value
//   en        : a joint x/w beat is present this cycle
//   x, w      : unsigned activation, signed weight
//   acc       : accumulator (wraps modulo 2^ACC_BITS)
// The product is registered; the accumulator consumes it one cycle later.
module mac_lane #(
    parameter int IN_BITS  = 4,
    parameter int W_BITS   = 4,
    parameter int ACC_BITS = 20
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       load,
    input  logic signed [ACC_BITS-1:0] load_val,
    input  logic                       en,
    input  logic        [IN_BITS-1:0]  x,
    input  logic signed [W_BITS-1:0]   w,
    output logic signed [ACC_BITS-1:0] acc
);
    localparam int P_BITS = IN_BITS + W_BITS + 1;

    logic signed [P_BITS-1:0] prod;
    logic                     prod_vld;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= en;
            if (en) begin
                prod <= P_BITS'($signed({1'b0, x})) * P_BITS'(w);
            end
            if (load) begin
                acc <= load_val;
            end else if (prod_vld) begin
                acc <= acc + ACC_BITS'(prod);
            end
        end
    end
endmodule

// File: rtl/cluster_layer.sv
// cluster_layer: fully-connected layer slice of NUM_NEURONS neurons over
// INPUT_SIZE inputs. Takes one bias beat, INPUT_SIZE joint x/w beats, then
// emits one requantised activation per neuron (neuron 0 first, a_tlast on
// the last).
//   CLK, RST : clock, synchronous active-low reset
//   bus      : cluster_layer_if.slave (x, w, b in; a out; status)
//
// state   | meaning
// S_BIAS  | waiting for the bias beat
// S_MAC   | consuming x/w beats
// S_DRAIN | last registered product being added
// S_OUT   | streaming activations
module cluster_layer
    import cluster_pkg::*;
#(
    parameter int INPUT_SIZE  = 784,
    parameter int NUM_NEURONS = 16,
    parameter int IN_BITS     = 4,
    parameter int W_BITS      = 4,
    parameter int B_BITS      = 4,
    parameter int ACC_BITS    = 20,
    parameter int B_SHIFT     = 4,
    parameter int OUT_SHIFT   = 7,
    parameter int OUT_BITS    = 4,
    parameter int RELU_EN     = 1
) (
    input logic            CLK,
    input logic            RST,
    cluster_layer_if.slave bus
);
    localparam int CNT_BITS = $clog2(INPUT_SIZE);
    localparam int IDX_BITS = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    state_t                     state;
    state_t                     state_nxt;
    logic                       rdy_en;
    logic [CNT_BITS-1:0]        pix_cnt;
    logic [IDX_BITS-1:0]        out_idx;
    logic [IDX_BITS-1:0]        idx_nxt;
    logic signed [ACC_BITS-1:0] acc [NUM_NEURONS];
    logic                       b_fire;
    logic                       beat;
    logic                       last_beat;
    logic                       a_fire;
    logic [OUT_BITS-1:0]        a_tdata_q;
    logic                       a_tvalid_q;
    logic                       a_tlast_q;
    logic [1:0]                 status_c;

    // rdy_en keeps all readies low while RST is held and for the release
    // edge itself, so nothing is accepted during reset.
    assign b_fire    = rdy_en && (state == S_BIAS) && bus.b_tvalid;
    assign beat      = (state == S_MAC) && bus.x_tvalid && bus.w_tvalid;
    assign last_beat = beat && (pix_cnt == CNT_BITS'(INPUT_SIZE - 1));
    assign a_fire    = a_tvalid_q && bus.a_tready;
    assign idx_nxt   = a_tvalid_q ? out_idx + 1'b1 : '0;

    assign bus.b_tready = rdy_en && (state == S_BIAS);
    assign bus.x_tready = (state == S_MAC) && bus.w_tvalid;
    assign bus.w_tready = (state == S_MAC) && bus.x_tvalid;
    assign bus.a_tdata  = a_tdata_q;
    assign bus.a_tvalid = a_tvalid_q;
    assign bus.a_tlast  = a_tlast_q;
    assign bus.status   = status_c;

    always_comb begin
        status_c = STATUS_IDLE;
        case (state)
            S_MAC, S_DRAIN: status_c = STATUS_COMPUTE;
            S_OUT:          status_c = STATUS_OUTPUT;
            default:        status_c = STATUS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_BIAS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BIAS:  if (b_fire) state_nxt = S_MAC;
            S_MAC:   if (last_beat) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   if (a_fire && a_tlast_q) state_nxt = S_BIAS;
            default: state_nxt = S_BIAS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rdy_en     <= 1'b0;
            pix_cnt    <= '0;
            out_idx    <= '0;
            a_tdata_q  <= '0;
            a_tvalid_q <= 1'b0;
            a_tlast_q  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (beat) begin
                pix_cnt <= last_beat ? '0 : pix_cnt + 1'b1;
            end
            // Load a new activation when the output register is empty or
            // its current value is being taken this cycle.
            if ((state == S_OUT) && (!a_tvalid_q || bus.a_tready)) begin
                if (a_tvalid_q && a_tlast_q) begin
                    a_tvalid_q <= 1'b0;
                    a_tlast_q  <= 1'b0;
                    out_idx    <= '0;
                end else begin
                    a_tvalid_q <= 1'b1;
                    out_idx    <= idx_nxt;
                    a_tdata_q  <= OUT_BITS'(requant(64'(acc[idx_nxt]), OUT_SHIFT,
                                                    OUT_BITS, RELU_EN != 0));
                    a_tlast_q  <= (idx_nxt == IDX_BITS'(NUM_NEURONS - 1));
                end
            end
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_lane
        logic signed [ACC_BITS-1:0] bias_ext;
        assign bias_ext = ACC_BITS'($signed(bus.b_tdata[n*B_BITS +: B_BITS])) <<< B_SHIFT;

        mac_lane #(
            .IN_BITS  (IN_BITS),
            .W_BITS   (W_BITS),
            .ACC_BITS (ACC_BITS)
        ) u_lane (
            .CLK      (CLK),
            .RST      (RST),
            .load     (b_fire),
            .load_val (bias_ext),
            .en       (beat),
            .x        (bus.x_tdata),
            .w        ($signed(bus.w_tdata[n*W_BITS +: W_BITS])),
            .acc      (acc[n])
        );
    end
endmodule

// File: doc/cluster_layer.md
Name: cluster_layer

Overview:
- Parametrised successor to the fixed 48-neuron cluster: one fully-connected layer slice of NUM_NEURONS neurons over INPUT_SIZE inputs.
- Flow: accept one bias beat, stream INPUT_SIZE (x, weight-vector) beats through signed MACs, then requantise (shift, optional ReLU, saturate).
- Emits one activation per neuron on an AXI-stream master with a_tlast.
- Sits between the pixel/weight DMA streams and the next layer's x input, so layers can be chained.

Parameters:
- INPUT_SIZE, 784, input beats per inference (>=2).
- NUM_NEURONS, 16, neurons (accumulators) in this slice.
- IN_BITS, 4, unsigned input activation width.
- W_BITS, 4, signed weight width.
- B_BITS, 4, signed bias width.
- ACC_BITS, 20, signed accumulator width; must be >= IN_BITS+W_BITS+1+clog2(INPUT_SIZE)+1.
- B_SHIFT, 4, left shift applied to the bias before it preloads the accumulator.
- OUT_SHIFT, 7, arithmetic right shift applied to the accumulator at output.
- OUT_BITS, 4, output activation width.
- RELU_EN, 1, 1 = ReLU plus unsigned saturation; 0 = signed saturation.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- x_tdata  in  IN_BITS  input activation.
- x_tvalid  in  1.
- x_tready  out  1.
- w_tdata  in  NUM_NEURONS*W_BITS  weight for neuron n in bits [n*W_BITS +: W_BITS].
- w_tvalid  in  1.
- w_tready  out  1.
- b_tdata  in  NUM_NEURONS*B_BITS  bias for neuron n in bits [n*B_BITS +: B_BITS].
- b_tvalid  in  1.
- b_tready  out  1.
- a_tdata  out  OUT_BITS  activation, neuron 0 first.
- a_tvalid  out  1.
- a_tready  in  1.
- a_tlast  out  1  high on neuron NUM_NEURONS-1.
- status  out  2  00 idle/bias wait, 01 computing, 10 outputting.

Behaviour:
- Clock and reset: one clock (CLK); RST is synchronous and active-low.
- Reset values: FSM=S_BIAS, all accumulators 0, pixel counter 0, output index 0, x/w/b_tready 0, a_tvalid 0, a_tdata 0, a_tlast 0, status 00.
- Readies are decoded from the registered state, so b_tready first rises the cycle after reset release.
- S_BIAS:
  - b_tready=1.
  - On b_tvalid: acc[n] <= sign_ext(b[n]) << B_SHIFT; go to S_MAC.
- S_MAC: x and w are consumed jointly.
  - x_tready = w_tvalid; w_tready = x_tvalid. Ready may depend on valid; valid never depends on ready.
  - A beat occurs when both valids are high. Bubbles on either stream stall with no side effect.
  - Per beat: product p[n] = $signed({1'b0,x}) * $signed(w[n]) is registered (1-cycle pipeline stage).
  - The accumulator adds the registered product on the following cycle.
  - Accumulation wraps modulo 2^ACC_BITS; no saturation at this stage.
  - After the INPUT_SIZE-th beat, readies drop the next cycle; go to S_DRAIN.
- S_DRAIN: exactly 1 cycle, adds the final registered product; go to S_OUT.
- S_OUT:
  - For index i: r = acc[i] >>> OUT_SHIFT.
  - RELU_EN=1: out = (r<0) ? 0 : min(r, 2^OUT_BITS-1).
  - RELU_EN=0: out = clamp(r, -2^(OUT_BITS-1), 2^(OUT_BITS-1)-1).
  - a_tdata/a_tlast are registered. a_tvalid rises the cycle after entering S_OUT.
  - Data is held stable until a_tready; on handshake, index++ and the next value loads back-to-back (one beat per cycle under full throughput).
  - After the handshake with a_tlast: a_tvalid <= 0, return to S_BIAS.
- Latency: last x/w beat to first a_tvalid = 3 cycles (product reg, drain add, output reg).
- Bias arrival: a b beat presented during S_MAC/S_DRAIN/S_OUT is not accepted (b_tready=0). It is accepted no earlier than the cycle after the last output handshake.
- Reset mid-operation (any state) aborts, clears accumulators and discards partial results. Counters return to 0.
- status: 00 in S_BIAS, 01 in S_MAC/S_DRAIN, 10 in S_OUT.

Decomposition:
- Shared package cluster_pkg holds:
  - state encoding (S_BIAS, S_MAC, S_DRAIN, S_OUT),
  - status codes,
  - function requant(acc, OUT_SHIFT, OUT_BITS, RELU_EN) returning the saturated activation.
- Sub-module mac_lane, instantiated NUM_NEURONS times:
  - ports: CLK, RST, load, load_val, en, x, w, acc.
  - contains the product register and accumulator.

Test Plan:
- Reset: hold RST=0 for 3 cycles with all valids high -> no handshakes, all outputs at reset values. One cycle after release: b_tready=1, status=00.
- Basic (INPUT_SIZE=4, NUM_NEURONS=2, B_SHIFT=0, OUT_SHIFT=0): bias {1,-2}, x=1,2,3,4, w n0=+1, n1=-1 -> accs 11 and -12 -> a_tdata 11 then 0, a_tlast on the second beat.
- Saturation: same config, x=15, w n0=7 for all beats, bias 0 -> acc 420 -> a_tdata 15.
- Stall/backpressure: basic stimulus with random x/w valid gaps and a_tready toggling -> identical outputs; a_tdata/a_tlast stable while a_tvalid&!a_tready; exactly 4 x/w beats consumed.
- Reset mid-op: assert RST after 2 MAC beats, then run basic stimulus -> outputs 11, 0 with no residue.
- Signed mode: RELU_EN=0, OUT_SHIFT=2, basic stimulus -> n0 = 11>>>2 = 2 (4'b0010), n1 = -12>>>2 = -3 (4'b1101).
